// File: rtl/fpadd_arbiter.sv
// ============================================================================
// Module   : fpadd_arbiter
// Brief    : Shares one combinational FP32 add/sub datapath between two
//            requesters. Round-robin grant, fixed ADD_LAT settle window,
//            result capture with overflow/underflow/invalid handling.
//            Optional macro FPADD_ARB_FIXED_PRIO_EN selects fixed priority
//            (port 0 wins contention) instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpadd_arbiter #(
    parameter int ADD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid_i,
    input  logic        req1_valid_i,
    output logic        req0_ready_o,
    output logic        req1_ready_o,
    input  logic [31:0] req0_a_i,
    input  logic [31:0] req0_b_i,
    input  logic [31:0] req1_a_i,
    input  logic [31:0] req1_b_i,
    input  logic        req0_sel_i,
    input  logic        req1_sel_i,
    output logic        rsp0_valid_o,
    output logic        rsp1_valid_o,
    input  logic        rsp0_ready_i,
    input  logic        rsp1_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_ovf_o,
    output logic        rsp_unf_o,
    output logic        rsp_inv_o,
    output logic [31:0] fa_a_o,
    output logic [31:0] fa_b_o,
    output logic        fa_sel_o,
    input  logic [31:0] fa_s_i,
    input  logic        fa_overflow_i,
    input  logic        fa_underflow_i
);

    localparam logic [31:0] C_QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] C_INF      = 32'h7F80_0000;
    localparam logic [3:0]  C_CNT_INIT = 4'(ADD_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        owner_q;
    logic        last_grant_q;   // 1 after reset so port 0 wins the first contention
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic        sel_q;
    logic [31:0] rsp_data_q;
    logic        rsp_ovf_q;
    logic        rsp_unf_q;
    logic        rsp_inv_q;

    logic        grant_d;
    logic        hs_d;
    logic [31:0] a_d;
    logic [31:0] b_d;
    logic        sel_d;
    logic        inv_d;

    // Grant selection and operand mux for the requester that would be accepted
    always_comb begin
        grant_d = req1_valid_i;
        if (req0_valid_i && req1_valid_i) begin
`ifdef FPADD_ARB_FIXED_PRIO_EN
            grant_d = 1'b0;
`else
            grant_d = ~last_grant_q;
`endif
        end
        // Gated by rst_n so no ready is shown while reset is held
        req0_ready_o = rst_n && (state_q == ST_IDLE) && req0_valid_i && !grant_d;
        req1_ready_o = rst_n && (state_q == ST_IDLE) && req1_valid_i &&  grant_d;
        hs_d         = req0_ready_o || req1_ready_o;
        a_d          = grant_d ? req1_a_i   : req0_a_i;
        b_d          = grant_d ? req1_b_i   : req0_b_i;
        sel_d        = grant_d ? req1_sel_i : req0_sel_i;
        // Exponent all-ones means inf or NaN on either operand
        inv_d        = (&a_d[30:23]) || (&b_d[30:23]);
    end

    // Sequencer: accept, hold operands for the settle window, capture, respond
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            opa_q        <= 32'd0;
            opb_q        <= 32'd0;
            sel_q        <= 1'b0;
            rsp_data_q   <= 32'd0;
            rsp_ovf_q    <= 1'b0;
            rsp_unf_q    <= 1'b0;
            rsp_inv_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hs_d) begin
                        opa_q        <= a_d;
                        opb_q        <= b_d;
                        sel_q        <= sel_d;
                        owner_q      <= grant_d;
                        last_grant_q <= grant_d;
                        if (inv_d) begin
                            // Adder output is never looked at for this operation
                            rsp_data_q <= C_QNAN;
                            rsp_ovf_q  <= 1'b0;
                            rsp_unf_q  <= 1'b0;
                            rsp_inv_q  <= 1'b1;
                            state_q    <= ST_RESP;
                        end else begin
                            cnt_q   <= C_CNT_INIT;
                            state_q <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == 4'd0) begin
                        // Overflow has priority over underflow
                        rsp_inv_q <= 1'b0;
                        if (fa_overflow_i) begin
                            rsp_data_q <= C_INF;
                            rsp_ovf_q  <= 1'b1;
                            rsp_unf_q  <= 1'b0;
                        end else if (fa_underflow_i) begin
                            rsp_data_q <= 32'd0;
                            rsp_ovf_q  <= 1'b0;
                            rsp_unf_q  <= 1'b1;
                        end else begin
                            rsp_data_q <= fa_s_i;
                            rsp_ovf_q  <= 1'b0;
                            rsp_unf_q  <= 1'b0;
                        end
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (owner_q ? rsp1_ready_i : rsp0_ready_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rsp0_valid_o = (state_q == ST_RESP) && !owner_q;
    assign rsp1_valid_o = (state_q == ST_RESP) &&  owner_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_ovf_o    = rsp_ovf_q;
    assign rsp_unf_o    = rsp_unf_q;
    assign rsp_inv_o    = rsp_inv_q;
    assign fa_a_o       = opa_q;
    assign fa_b_o       = opb_q;
    assign fa_sel_o     = sel_q;

endmodule

`default_nettype wire

// File: doc/fpadd_arbiter.md
# fpadd_arbiter

Sequencer that shares one single-precision floating-point add/subtract datapath between two requesters. Round-robin arbitration with valid/ready handshakes, a fixed multi-cycle settle window for the combinational adder, and result capture with exception handling. Sits between the requesting logic and the adder instance, whose operand inputs it drives and whose sum and overflow/underflow outputs it consumes.

## Interface
- ADD_LAT, default 2: cycles the adder inputs are held stable before the result is sampled; legal range 1..15.
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid / req1_valid  in  1  the requester has an operation pending.
- req0_ready / req1_ready  out  1  the request is accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  32  IEEE-754 single-precision operands.
- req0_sel / req1_sel  in  1  operation select: 0 = add, 1 = subtract.
- rsp0_valid / rsp1_valid  out  1  a result is available for that requester.
- rsp0_ready / rsp1_ready  in  1  the requester takes the result.
- rsp_data  out  32  result word, shared by both response ports.
- rsp_ovf, rsp_unf, rsp_inv  out  1  overflow, underflow and invalid-operand flags, shared.
- fa_a, fa_b  out  32  operands to the adder.
- fa_sel  out  1  operation select to the adder.
- fa_s  in  32  sum from the adder.
- fa_overflow, fa_underflow  in  1  status flags from the adder.

## Operation
- States: IDLE, EXEC, RESP.
- **IDLE**
  - Grant logic is combinational.
  - If only one req*_valid is high, that requester is granted.
  - If both are high, the requester not recorded in last_grant is granted.
  - reqN_ready = (state==IDLE) && granted N. Only one ready is ever high.
  - On handshake (valid && ready):
    - Register a, b and sel into the operand registers and record the grant in owner and last_grant.
    - Invalid check: either operand has exponent 8'hFF (inf or NaN). If so, load rsp_data=32'h7FC00000 and rsp_inv=1, then go to RESP without using the adder.
    - Otherwise load the cycle counter with ADD_LAT-1 and go to EXEC.
- **fa_a, fa_b, fa_sel**
  - Always driven from the operand registers; they change only on a handshake.
- **EXEC**
  - Counter decrements each cycle.
  - When the counter reaches 0, capture the result and go to RESP.
  - fa_overflow=1: rsp_data = {fa_s[31] & ~fa_s[31]... → 0}, i.e. 32'h7F800000, with rsp_ovf=1.
  - Else fa_underflow=1: rsp_data=32'h00000000, rsp_unf=1.
  - Else rsp_data=fa_s with all flags 0.
  - If both adder flags are high, overflow wins.
- **RESP**
  - rsp{owner}_valid=1; the other rsp*_valid stays 0.
  - When rsp{owner}_ready=1, go to IDLE on the next edge.
  - rsp_data and the flags hold until the next capture.
- Requests arriving outside IDLE wait; the requester must hold valid and operands stable until ready.
- The block has no buffering; at most one operation is in flight.

## Timing
- Reset values:
  - state=IDLE, last_grant=1 (port 0 wins the first contention).
  - All req*_ready, rsp*_valid, rsp_* flags, rsp_data, fa_a, fa_b, fa_sel = 0.
- Latency, normal path:
  - Handshake at cycle 0 → EXEC during cycles 1..ADD_LAT → rsp valid from cycle ADD_LAT+1.
  - Back-to-back throughput with rsp_ready tied high is one operation per ADD_LAT+2 cycles.
- Latency, invalid path: rsp valid at cycle 1.
- Adder settle: the operands are stable for a full ADD_LAT cycles before sampling, so the combinational adder gets ADD_LAT clock periods.
- Reset mid-operation: returns to IDLE immediately. The in-flight operation is discarded and no response is issued.
- Simultaneous rsp handshake and new request: a new request can only be accepted in the IDLE cycle after RESP; there is no same-cycle overlap.

## Configuration
- FPADD_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, port 0 always wins when both are valid. last_grant is still updated but ignored by the grant logic.
  - Undefined (default): round-robin as described under Operation.

## Test plan
- Single add on port 0: a=32'h3F800000, b=32'h40000000, sel=0, adder model returns 32'h40400000, ADD_LAT=2.
  - req0_ready at cycle 0.
  - rsp0_valid at cycle 3 with rsp_data=32'h40400000 and all flags 0.
  - rsp1_valid stays 0 throughout.
- Contention: both ports valid continuously, rsp_ready high.
  - Grants alternate 0,1,0,1.
  - With FPADD_ARB_FIXED_PRIO_EN defined, all grants go to port 0.
- Invalid operand: req1 a=32'h7F800000.
  - rsp1_valid at cycle 1 with rsp_data=32'h7FC00000 and rsp_inv=1.
  - fa_* are loaded but the adder result is ignored.
- Overflow: adder model asserts fa_overflow (and, separately, fa_overflow with fa_underflow both high).
  - rsp_data=32'h7F800000, rsp_ovf=1, rsp_unf=0 in both cases.
- Backpressure: rsp0_ready held low for 5 cycles while req1_valid=1.
  - rsp0_valid and rsp_data stay stable.
  - req1_ready stays 0 until one cycle after rsp0_ready rises.
- Reset asserted in EXEC.
  - All outputs are 0 asynchronously.
  - After release, the next request is served normally and no stale response appears.
